// File: rtl/room_loader.sv
// room_loader: byte-stream command loader for the room cmd/rsp slave port.
// Parses 'R'/'W' frames from RX, issues one room command, and replies on TX.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for an opcode byte
// ADDR   | collecting AW/8 little-endian address bytes
// DATA   | collecting DW/8 little-endian write data bytes
// CMD    | command presented to room (CPU held) until response/timeout
// RESP   | selecting the reply bytes from the captured response
// TX     | sending reply bytes, RX back-pressured
module room_loader #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_rx_valid,
   input  logic [7:0]      i_rx_data,
   output logic            o_rx_ready,
   output logic            o_tx_valid,
   output logic [7:0]      o_tx_data,
   input  logic            i_tx_ready,
   output logic            o_cmd_valid,
   output logic [AW-1:0]   o_cmd_addr,
   output logic            o_cmd_read,
   output logic [DW-1:0]   o_cmd_wdata,
   output logic [DW/8-1:0] o_cmd_wmask,
   input  logic            i_rsp_valid,
   input  logic            i_rsp_err,
   input  logic [DW-1:0]   i_rsp_rdata,
   output logic            o_busy
);

   localparam int NB   = DW / 8;
   localparam int AB   = AW / 8;
   localparam int CMAX = (AB > NB) ? AB : NB;
   localparam int CW   = $clog2(CMAX) + 1;
   localparam int TW   = $clog2(TIMEOUT + 1);

   localparam logic [7:0] C_RD  = 8'h52;
   localparam logic [7:0] C_WR  = 8'h57;
   localparam logic [7:0] C_BAD = 8'h3F;
   localparam logic [7:0] C_TMO = 8'h54;
   localparam logic [7:0] C_ERR = 8'h45;
   localparam logic [7:0] C_OK  = 8'h4B;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_CMD, S_RESP, S_TX
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [TW-1:0]   r_tmo;
   logic [AW-1:0]   r_addr;
   logic            r_read;
   logic [DW-1:0]   r_wdata;
   logic [NB-1:0]   r_wmask;
   logic [DW-1:0]   r_rdata;
   logic            r_err;
   logic [7:0]      r_tx_data;
   logic [CW-1:0]   r_tx_idx;
   logic [CW-1:0]   r_tx_last;

   logic            w_rx_fire;
   logic            w_tx_fire;
   logic [CW-1:0]   w_tx_next;

   assign o_rx_ready  = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA);
   assign o_tx_valid  = (r_state == S_TX);
   assign o_cmd_valid = (r_state == S_CMD);
   assign o_busy      = (r_state != S_IDLE);
   assign o_tx_data   = r_tx_data;
   assign o_cmd_addr  = r_addr;
   assign o_cmd_read  = r_read;
   assign o_cmd_wdata = r_wdata;
   assign o_cmd_wmask = r_wmask;

   assign w_rx_fire = i_rx_valid && o_rx_ready;
   assign w_tx_fire = o_tx_valid && i_tx_ready;
   assign w_tx_next = r_tx_idx + 1'b1;

   // Frame parser, command issue, timeout and reply sequencing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_tmo     <= '0;
         r_addr    <= '0;
         r_read    <= 1'b0;
         r_wdata   <= '0;
         r_wmask   <= '0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
         r_tx_data <= '0;
         r_tx_idx  <= '0;
         r_tx_last <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_rx_fire) begin
                  if (i_rx_data == C_RD || i_rx_data == C_WR) begin
                     r_read  <= (i_rx_data == C_RD);
                     r_cnt   <= '0;
                     r_state <= S_ADDR;
                  end else begin
                     r_tx_data <= C_BAD;
                     r_tx_idx  <= '0;
                     r_tx_last <= '0;
                     r_state   <= S_TX;
                  end
               end
            end
            S_ADDR: begin
               if (w_rx_fire) begin
                  r_addr[8*r_cnt +: 8] <= i_rx_data;
                  if (r_cnt == CW'(AB - 1)) begin
                     r_cnt <= '0;
                     if (r_read) begin
                        r_tmo   <= '0;
                        r_state <= S_CMD;
                     end else begin
                        r_state <= S_DATA;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (w_rx_fire) begin
                  r_wdata[8*r_cnt +: 8] <= i_rx_data;
                  if (r_cnt == CW'(NB - 1)) begin
                     r_cnt   <= '0;
                     r_wmask <= '1;
                     r_tmo   <= '0;
                     r_state <= S_CMD;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            S_CMD: begin
               // A response on the final timeout cycle still wins.
               if (i_rsp_valid) begin
                  r_err   <= i_rsp_err;
                  r_rdata <= i_rsp_rdata;
                  r_state <= S_RESP;
               end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                  r_tx_data <= C_TMO;
                  r_tx_idx  <= '0;
                  r_tx_last <= '0;
                  r_state   <= S_TX;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            S_RESP: begin
               r_tx_idx <= '0;
               if (r_err) begin
                  r_tx_data <= C_ERR;
                  r_tx_last <= '0;
               end else if (r_read) begin
                  r_tx_data <= r_rdata[7:0];
                  r_tx_last <= CW'(NB - 1);
               end else begin
                  r_tx_data <= C_OK;
                  r_tx_last <= '0;
               end
               r_state <= S_TX;
            end
            S_TX: begin
               if (w_tx_fire) begin
                  if (r_tx_idx == r_tx_last) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_tx_idx  <= w_tx_next;
                     r_tx_data <= r_rdata[8*w_tx_next +: 8];
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_room_loader.sv
// tb_room_loader: directed bench for room_loader with a short timeout.
module tb_room_loader;

   logic        clk;
   logic        rst_n;
   logic        i_rx_valid;
   logic [7:0]  i_rx_data;
   logic        o_rx_ready;
   logic        o_tx_valid;
   logic [7:0]  o_tx_data;
   logic        i_tx_ready;
   logic        o_cmd_valid;
   logic [31:0] o_cmd_addr;
   logic        o_cmd_read;
   logic [31:0] o_cmd_wdata;
   logic [3:0]  o_cmd_wmask;
   logic        i_rsp_valid;
   logic        i_rsp_err;
   logic [31:0] i_rsp_rdata;
   logic        o_busy;

   int total = 0;
   int bad   = 0;

   room_loader #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_rx_ready(o_rx_ready),
      .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
      .o_cmd_valid(o_cmd_valid), .o_cmd_addr(o_cmd_addr), .o_cmd_read(o_cmd_read),
      .o_cmd_wdata(o_cmd_wdata), .o_cmd_wmask(o_cmd_wmask),
      .i_rsp_valid(i_rsp_valid), .i_rsp_err(i_rsp_err), .i_rsp_rdata(i_rsp_rdata),
      .o_busy(o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      i_rx_valid = 1'b1;
      i_rx_data  = b;
      while (!o_rx_ready && n < 50) begin tick(); n++; end
      total++;
      if (o_rx_ready !== 1'b1) begin bad++; $display("FAIL rx_accept byte=%h ready=%b exp 1", b, o_rx_ready); end
      tick();
      i_rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic is_wr, input logic [31:0] addr, input logic [31:0] data);
      send_byte(is_wr ? 8'h57 : 8'h52);
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
      if (is_wr) for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
   endtask

   task automatic wait_cmd();
      int n = 0;
      while (!o_cmd_valid && n < 50) begin tick(); n++; end
      total++;
      if (o_cmd_valid !== 1'b1) begin bad++; $display("FAIL cmd_start got %b exp 1", o_cmd_valid); end
   endtask

   task automatic respond(input logic err, input logic [31:0] rd);
      i_rsp_valid = 1'b1;
      i_rsp_err   = err;
      i_rsp_rdata = rd;
      tick();
      i_rsp_valid = 1'b0;
      i_rsp_err   = 1'b0;
   endtask

   task automatic recv_byte(input string name, input logic [7:0] exp);
      int n = 0;
      i_tx_ready = 1'b1;
      while (!o_tx_valid && n < 50) begin tick(); n++; end
      total++;
      if (o_tx_valid !== 1'b1 || o_tx_data !== exp) begin
         bad++; $display("FAIL %s valid=%b data=%h exp %h", name, o_tx_valid, o_tx_data, exp);
      end
      tick();
      i_tx_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_rx_valid = 0; i_rx_data = 0; i_tx_ready = 0;
      i_rsp_valid = 0; i_rsp_err = 0; i_rsp_rdata = 0;
      #12;
      total++;
      if ({o_cmd_valid, o_tx_valid, o_tx_data, o_rx_ready, o_busy} !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
         bad++; $display("FAIL reset_outs cv=%b tv=%b td=%h rr=%b busy=%b", o_cmd_valid, o_tx_valid, o_tx_data, o_rx_ready, o_busy);
      end
      total++;
      if ({o_cmd_addr, o_cmd_wdata, o_cmd_wmask} !== 68'h0) begin
         bad++; $display("FAIL reset_regs addr=%h wdata=%h mask=%h exp 0", o_cmd_addr, o_cmd_wdata, o_cmd_wmask);
      end
      @(negedge clk); rst_n = 1'b1;
      tick();
   endtask

   task automatic test_write();
      int n = 0;
      send_frame(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
      wait_cmd();
      total++;
      if ({o_cmd_addr, o_cmd_read, o_cmd_wdata, o_cmd_wmask} !== {32'h100, 1'b0, 32'hDEADBEEF, 4'hF}) begin
         bad++; $display("FAIL write_cmd addr=%h rd=%b wd=%h m=%h", o_cmd_addr, o_cmd_read, o_cmd_wdata, o_cmd_wmask);
      end
      total++;
      if (o_rx_ready !== 1'b0 || o_busy !== 1'b1) begin bad++; $display("FAIL write_cmd_flags rr=%b busy=%b exp 0/1", o_rx_ready, o_busy); end
      tick(); tick();
      respond(1'b0, 32'h0);
      total++;
      if (o_cmd_valid !== 1'b0) begin bad++; $display("FAIL write_cmd_drop got %b exp 0", o_cmd_valid); end
      recv_byte("write_ok", 8'h4B);
      total++;
      if (o_busy !== 1'b0) begin bad++; $display("FAIL write_idle busy=%b exp 0", o_busy); end
   endtask

   task automatic test_read();
      send_frame(1'b0, 32'h0000_0100, 32'h0);
      wait_cmd();
      total++;
      if (o_cmd_read !== 1'b1 || o_cmd_addr !== 32'h100) begin
         bad++; $display("FAIL read_cmd rd=%b addr=%h exp 1/00000100", o_cmd_read, o_cmd_addr);
      end
      respond(1'b0, 32'hDEADBEEF);
      recv_byte("read_b0", 8'hEF);
      recv_byte("read_b1", 8'hBE);
      recv_byte("read_b2", 8'hAD);
      recv_byte("read_b3", 8'hDE);
      total++;
      if (o_busy !== 1'b0) begin bad++; $display("FAIL read_idle busy=%b exp 0", o_busy); end
   endtask

   task automatic test_error();
      send_frame(1'b1, 32'h1234_5678, 32'h0BAD_F00D);
      wait_cmd();
      respond(1'b1, 32'h0);
      recv_byte("rsp_err", 8'h45);
   endtask

   task automatic test_timeout();
      int n = 0;
      send_frame(1'b0, 32'h0000_0040, 32'h0);
      while (o_cmd_valid && n < 50) begin n++; tick(); end
      total++;
      if (n != 8) begin bad++; $display("FAIL timeout_len got %0d cycles exp 8", n); end
      recv_byte("timeout_T", 8'h54);
      total++;
      if (o_busy !== 1'b0) begin bad++; $display("FAIL timeout_idle busy=%b exp 0", o_busy); end
   endtask

   task automatic test_late_rsp();
      send_frame(1'b1, 32'h0000_0008, 32'h0000_0001);
      wait_cmd();
      repeat (7) tick();
      total++;
      if (o_cmd_valid !== 1'b1) begin bad++; $display("FAIL late_cmd_held got %b exp 1", o_cmd_valid); end
      respond(1'b0, 32'h0);
      recv_byte("late_rsp_wins", 8'h4B);
   endtask

   task automatic test_backpressure();
      logic [7:0] first;
      send_frame(1'b0, 32'h0000_0200, 32'h0);
      wait_cmd();
      respond(1'b0, 32'h11223344);
      i_rx_valid = 1'b1;
      i_rx_data  = 8'h41;
      tick();
      first = 8'h44;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (o_tx_valid !== 1'b1 || o_tx_data !== first || o_rx_ready !== 1'b0) begin
            bad++; $display("FAIL bp_hold cyc=%0d tv=%b td=%h rr=%b exp 1/%h/0", i, o_tx_valid, o_tx_data, o_rx_ready, first);
         end
         tick();
      end
      recv_byte("bp_b0", 8'h44);
      recv_byte("bp_b1", 8'h33);
      recv_byte("bp_b2", 8'h22);
      recv_byte("bp_b3", 8'h11);
      total++;
      if (o_rx_ready !== 1'b1) begin bad++; $display("FAIL bp_rx_pending rr=%b exp 1", o_rx_ready); end
      tick();
      i_rx_valid = 1'b0;
      recv_byte("bad_opcode", 8'h3F);
   endtask

   task automatic test_reset_mid_cmd();
      send_frame(1'b1, 32'h0000_0300, 32'hCAFE_0001);
      wait_cmd();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({o_cmd_valid, o_busy, o_tx_valid, o_rx_ready} !== 4'b0001) begin
         bad++; $display("FAIL rst_mid_cmd cv=%b busy=%b tv=%b rr=%b exp 0/0/0/1", o_cmd_valid, o_busy, o_tx_valid, o_rx_ready);
      end
      total++;
      if ({o_cmd_addr, o_cmd_wmask} !== 36'h0) begin
         bad++; $display("FAIL rst_mid_regs addr=%h mask=%h exp 0", o_cmd_addr, o_cmd_wmask);
      end
      @(negedge clk); rst_n = 1'b1;
      tick();
      send_frame(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
      wait_cmd();
      total++;
      if ({o_cmd_addr, o_cmd_wdata, o_cmd_wmask} !== {32'h100, 32'hDEADBEEF, 4'hF}) begin
         bad++; $display("FAIL post_rst_cmd addr=%h wd=%h m=%h", o_cmd_addr, o_cmd_wdata, o_cmd_wmask);
      end
      respond(1'b0, 32'h0);
      recv_byte("post_rst_ok", 8'h4B);
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_error();
      test_timeout();
      test_late_rsp();
      test_backpressure();
      test_reset_mid_cmd();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
